// File: rtl/fbuff_writer.sv
// Packs TILES_PER_ROW tile colours into one frame buffer row and writes it; can also flood-fill the whole buffer with one colour.
// Latency: a row is written one cycle after its last tile handshake; a clear takes FBUFF_DEPTH cycles.
// Backpressure: tile_ready_o drops while a row write or clear is under way, or while frame_start_i/clear_req_i is asserted.
module fbuff_writer #(
  parameter int COLR_PXL_WIDTH   = 12,
  parameter int TILES_PER_ROW    = 5,
  parameter int FBUFF_DATA_WIDTH = 60,
  parameter int FBUFF_ADDR_WIDTH = 12,
  parameter int FBUFF_DEPTH      = 3840
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        tile_valid_i,
  input  logic [COLR_PXL_WIDTH-1:0]   tile_data_i,
  output logic                        tile_ready_o,
  input  logic                        frame_start_i,
  input  logic                        clear_req_i,
  input  logic [COLR_PXL_WIDTH-1:0]   clear_colr_i,
  output logic                        busy_o,
  output logic                        frame_done_o,
  output logic                        fbuff_en_o,
  output logic                        fbuff_we_o,
  output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
  output logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_o
);

  localparam int CTR_W = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1;
  localparam logic [FBUFF_ADDR_WIDTH-1:0] LAST_ADDR = FBUFF_ADDR_WIDTH'(FBUFF_DEPTH - 1);
  localparam logic [CTR_W-1:0]            LAST_TILE = CTR_W'(TILES_PER_ROW - 1);

  typedef enum logic [1:0] {ACCEPT, WRITE, CLEAR} state_t;

  state_t                      state_q, state_d;
  logic [CTR_W-1:0]            tile_ctr;
  logic [FBUFF_DATA_WIDTH-1:0] pack_r;
  logic [FBUFF_ADDR_WIDTH-1:0] addr_r;
  logic [COLR_PXL_WIDTH-1:0]   clr_colr_r;
  // Last driven address/data, so the buffer port stays stable between writes.
  logic [FBUFF_ADDR_WIDTH-1:0] addr_hold;
  logic [FBUFF_DATA_WIDTH-1:0] data_hold;
  logic                        tile_hs;
  logic                        at_last_addr;

  // Ready is gated by reset so nothing is accepted while the block is held in reset.
  assign tile_ready_o = (state_q == ACCEPT) && !clear_req_i && !frame_start_i && !rst_i;
  assign tile_hs      = tile_valid_i && tile_ready_o;
  assign at_last_addr = (addr_r == LAST_ADDR);

  // State register; async reset aborts any write or clear on the spot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ACCEPT;
    else       state_q <= state_d;
  end

  // Next-state and frame buffer port drive.
  always_comb begin
    state_d      = state_q;
    busy_o       = 1'b0;
    fbuff_en_o   = 1'b0;
    fbuff_we_o   = 1'b0;
    frame_done_o = 1'b0;
    fbuff_addr_o = addr_hold;
    fbuff_data_o = data_hold;
    case (state_q)
      ACCEPT: begin
        if (clear_req_i)                              state_d = CLEAR;
        else if (tile_hs && (tile_ctr == LAST_TILE))  state_d = WRITE;
      end
      WRITE: begin
        busy_o       = 1'b1;
        fbuff_en_o   = 1'b1;
        fbuff_we_o   = 1'b1;
        fbuff_addr_o = addr_r;
        fbuff_data_o = pack_r;
        frame_done_o = at_last_addr;
        state_d      = ACCEPT;
      end
      CLEAR: begin
        busy_o       = 1'b1;
        fbuff_en_o   = 1'b1;
        fbuff_we_o   = 1'b1;
        fbuff_addr_o = addr_r;
        fbuff_data_o = {TILES_PER_ROW{clr_colr_r}};
        frame_done_o = at_last_addr;
        if (at_last_addr) state_d = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  // Tile packing, row address walk, clear colour latch and output hold registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tile_ctr   <= '0;
      pack_r     <= '0;
      addr_r     <= '0;
      clr_colr_r <= '0;
      addr_hold  <= '0;
      data_hold  <= '0;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (clear_req_i) begin
            clr_colr_r <= clear_colr_i;
            tile_ctr   <= '0;
            addr_r     <= '0;
          end else if (frame_start_i) begin
            tile_ctr   <= '0;
            addr_r     <= '0;
          end else if (tile_hs) begin
            pack_r[int'(tile_ctr)*COLR_PXL_WIDTH +: COLR_PXL_WIDTH] <= tile_data_i;
            tile_ctr <= (tile_ctr == LAST_TILE) ? '0 : tile_ctr + CTR_W'(1);
          end
        end
        WRITE, CLEAR: begin
          addr_r    <= at_last_addr ? '0 : addr_r + FBUFF_ADDR_WIDTH'(1);
          addr_hold <= fbuff_addr_o;
          data_hold <= fbuff_data_o;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fbuff_writer.sv
// Bench for fbuff_writer: directed scenarios plus random traffic, every cycle checked against a queue-based model.
module tb_fbuff_writer;

  localparam int CW    = 12;
  localparam int TPR   = 5;
  localparam int DW    = 60;
  localparam int AW    = 12;
  localparam int DEPTH = 3840;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          tile_valid_i = 1'b0;
  logic [CW-1:0] tile_data_i = '0;
  logic          tile_ready_o;
  logic          frame_start_i = 1'b0;
  logic          clear_req_i = 1'b0;
  logic [CW-1:0] clear_colr_i = '0;
  logic          busy_o, frame_done_o, fbuff_en_o, fbuff_we_o;
  logic [AW-1:0] fbuff_addr_o;
  logic [DW-1:0] fbuff_data_o;

  fbuff_writer #(
    .COLR_PXL_WIDTH(CW), .TILES_PER_ROW(TPR), .FBUFF_DATA_WIDTH(DW),
    .FBUFF_ADDR_WIDTH(AW), .FBUFF_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tile_valid_i(tile_valid_i), .tile_data_i(tile_data_i), .tile_ready_o(tile_ready_o),
    .frame_start_i(frame_start_i), .clear_req_i(clear_req_i), .clear_colr_i(clear_colr_i),
    .busy_o(busy_o), .frame_done_o(frame_done_o),
    .fbuff_en_o(fbuff_en_o), .fbuff_we_o(fbuff_we_o),
    .fbuff_addr_o(fbuff_addr_o), .fbuff_data_o(fbuff_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Model: transaction-level view of what the buffer must see.
  logic [CW-1:0] m_tiles[$];
  int            m_clear_left = 0;   // clear rows still to be written
  logic [CW-1:0] m_colr = '0;
  bit            m_row_due = 0;      // a packed row waits to be written
  logic [DW-1:0] m_row = '0;
  int            m_addr = 0;         // address of the next tile row
  int            m_last_a = 0;
  logic [DW-1:0] m_last_d = '0;

  // Observation counters for scenario-level checks.
  int n_wr = 0;
  int n_done = 0;
  int last_done_addr = -1;
  int last_wr_addr = -1;
  logic [DW-1:0] last_wr_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [CW-1:0] c);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < TPR; i++) r[i*CW +: CW] = c;
    return r;
  endfunction

  function automatic logic [DW-1:0] pack_q();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < TPR; i++) r[i*CW +: CW] = m_tiles[i];
    return r;
  endfunction

  task automatic model_reset();
    m_tiles.delete();
    m_clear_left = 0;
    m_colr = '0;
    m_row_due = 0;
    m_row = '0;
    m_addr = 0;
    m_last_a = 0;
    m_last_d = '0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit v, input logic [CW-1:0] d, input bit fs, input bit cr,
                      input logic [CW-1:0] cc);
    bit            ew, edone, erdy;
    int            ea;
    logic [DW-1:0] ed;
    @(negedge clk_i);
    tile_valid_i = v; tile_data_i = d; frame_start_i = fs;
    clear_req_i = cr; clear_colr_i = cc;
    #1;
    if (m_clear_left > 0) begin
      ew = 1; ea = DEPTH - m_clear_left; ed = rep(m_colr);
    end else if (m_row_due) begin
      ew = 1; ea = m_addr; ed = m_row;
    end else begin
      ew = 0; ea = m_last_a; ed = m_last_d;
    end
    edone = ew && (ea == DEPTH - 1);
    erdy  = !ew && !cr && !fs;
    chk("ready", 64'(tile_ready_o), 64'(erdy));
    chk("busy",  64'(busy_o),       64'(ew));
    chk("en",    64'(fbuff_en_o),   64'(ew));
    chk("we",    64'(fbuff_we_o),   64'(ew));
    chk("done",  64'(frame_done_o), 64'(edone));
    chk("addr",  64'(fbuff_addr_o), 64'(ea));
    chk("data",  64'(fbuff_data_o), 64'(ed));
    if (fbuff_we_o) begin
      n_wr++; last_wr_addr = int'(fbuff_addr_o); last_wr_data = fbuff_data_o;
    end
    if (frame_done_o) begin
      n_done++; last_done_addr = int'(fbuff_addr_o);
    end
    if (ew) begin
      m_last_a = ea; m_last_d = ed;
      if (m_clear_left > 0) m_clear_left--;
      else begin
        m_row_due = 0;
        m_addr = (m_addr + 1) % DEPTH;
      end
    end else if (cr) begin
      m_clear_left = DEPTH; m_colr = cc; m_tiles.delete(); m_addr = 0;
    end else if (fs) begin
      m_tiles.delete(); m_addr = 0;
    end else if (v) begin
      m_tiles.push_back(d);
      if (m_tiles.size() == TPR) begin
        m_row = pack_q(); m_row_due = 1; m_tiles.delete();
      end
    end
  endtask

  task automatic idle(); step(0, '0, 0, 0, '0); endtask
  task automatic tile(input logic [CW-1:0] d); step(1, d, 0, 0, '0); endtask

  task automatic clear_counters();
    n_wr = 0; n_done = 0; last_done_addr = -1;
  endtask

  initial begin
    logic [CW-1:0] rd;
    // Reset state.
    #1;
    chk("rst_ready", 64'(tile_ready_o), 0);
    chk("rst_busy",  64'(busy_o), 0);
    chk("rst_we",    64'(fbuff_we_o), 0);
    chk("rst_en",    64'(fbuff_en_o), 0);
    chk("rst_done",  64'(frame_done_o), 0);
    chk("rst_addr",  64'(fbuff_addr_o), 0);
    chk("rst_data",  64'(fbuff_data_o), 0);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    idle();

    // Five back-to-back tiles 1..5 -> one write to addr 0, one cycle later.
    for (int i = 1; i <= 5; i++) tile(CW'(i));
    clear_counters();
    idle();
    chk("row1_wr",   64'(n_wr), 1);
    chk("row1_addr", 64'(last_wr_addr), 0);
    chk("row1_data", 64'(last_wr_data), 64'h005004003002001);
    idle();
    chk("row1_busy_off", 64'(busy_o), 0);

    // Partial row discarded by frame_start.
    for (int i = 0; i < 3; i++) tile(12'h123);
    step(1, 12'h555, 1, 0, '0);
    clear_counters();
    for (int i = 0; i < 5; i++) tile(12'hAAA);
    idle(); idle();
    chk("fs_wr",   64'(n_wr), 1);
    chk("fs_addr", 64'(last_wr_addr), 0);
    chk("fs_data", 64'(last_wr_data), 64'hAAAAAAAAAAAAAAA);

    // Full frame streamed, then one more row wraps to addr 0.
    step(0, '0, 1, 0, '0);
    clear_counters();
    for (int r = 0; r < DEPTH; r++) begin
      for (int i = 0; i < 5; i++) tile(CW'($urandom));
      idle();
    end
    chk("frame_wr",        64'(n_wr), DEPTH);
    chk("frame_done_cnt",  64'(n_done), 1);
    chk("frame_done_addr", 64'(last_done_addr), DEPTH - 1);
    for (int i = 0; i < 5; i++) tile(CW'($urandom));
    idle();
    chk("wrap_addr", 64'(last_wr_addr), 0);

    // Clear with tile_valid held high.
    step(1, 12'h111, 0, 1, 12'hF00);
    clear_counters();
    for (int i = 0; i < DEPTH; i++) step(1, CW'($urandom), 0, 0, 12'h0F0);
    chk("clr_wr",        64'(n_wr), DEPTH);
    chk("clr_done_cnt",  64'(n_done), 1);
    chk("clr_done_addr", 64'(last_done_addr), DEPTH - 1);
    chk("clr_data",      64'(last_wr_data), 64'hF00F00F00F00F00);
    idle();
    chk("clr_accept", 64'(tile_ready_o), 1);
    for (int i = 0; i < 5; i++) tile(12'h0B0);
    idle();
    chk("clr_after_addr", 64'(last_wr_addr), 0);

    // Clear and frame_start in the same cycle: clear wins.
    step(0, '0, 1, 1, 12'h00C);
    clear_counters();
    for (int i = 0; i < DEPTH + 2; i++) step(0, '0, 1, 0, '0);
    chk("prio_wr", 64'(n_wr), DEPTH);

    // Reset at clear write 100.
    step(0, '0, 0, 1, 12'h777);
    for (int i = 0; i < 100; i++) idle();
    @(negedge clk_i);
    #1;
    chk("pre_rst_we",   64'(fbuff_we_o), 1);
    chk("pre_rst_addr", 64'(fbuff_addr_o), 100);
    rst_i = 1'b1;
    #1;
    chk("async_we",   64'(fbuff_we_o), 0);
    chk("async_busy", 64'(busy_o), 0);
    chk("async_addr", 64'(fbuff_addr_o), 0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_counters();
    for (int i = 0; i < 5; i++) tile(12'h321);
    idle();
    chk("post_rst_wr",   64'(n_wr), 1);
    chk("post_rst_addr", 64'(last_wr_addr), 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rd = CW'($urandom);
      step(($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 1999) == 0), CW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
